// File: rtl/barcode_pkg.sv
// Shared definitions for the parametrised barcode station-ID receiver.
package barcode_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_FALL = 3'd2,
    DELAY     = 3'd3,
    WAIT_RISE = 3'd4,
    DONE      = 3'd5,
    ABORT     = 3'd6,
    WAIT_IDLE = 3'd7
  } bc_state_e;

  localparam int unsigned DEF_ID_W     = 32'd8;
  localparam int unsigned DEF_CHK_W    = 32'd2;
  localparam int unsigned DEF_TMR_W    = 32'd22;
  localparam int unsigned DEF_MIN_HALF = 32'd16;
  localparam int unsigned DEF_TO_SHIFT = 32'd3;

endpackage

// File: rtl/bc_sync.sv
// Negedge two-flop synchroniser for the asynchronous IR sensor line.
module bc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two negedge stages; preset high so reset looks like an idle line
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/barcode_rx_param.sv
// Pulse-width barcode receiver: measures the start bit, samples each data bit
// one half-period after its falling edge, and hands a checked ID to the core.
module barcode_rx_param
  import barcode_pkg::*;
#(
  parameter int unsigned ID_W     = DEF_ID_W,
  parameter int unsigned CHK_W    = DEF_CHK_W,
  parameter int unsigned TMR_W    = DEF_TMR_W,
  parameter int unsigned MIN_HALF = DEF_MIN_HALF,
  parameter int unsigned TO_SHIFT = DEF_TO_SHIFT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            BC,
  input  logic            clr_ID_vld,
  output logic [ID_W-1:0] ID,
  output logic            ID_vld,
  output logic            ID_err,
  output logic            overrun,
  output logic            busy
);

  localparam int unsigned LIM_W = TMR_W + TO_SHIFT;
  localparam int unsigned CNT_W = $clog2(ID_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ID_W - 1);

  bc_state_e        state_r;
  logic             bc_s;
  logic [TMR_W-1:0] half_r;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] wdog_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [ID_W-1:0]  shreg_r;
  logic [LIM_W-1:0] limit_s;
  logic             wdog_exp_s;
  logic             id_legal_s;

  bc_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (BC),
    .q     (bc_s)
  );

  // Watchdog limit is widened before the shift so it can never be truncated;
  // a saturated watchdog also counts as expired so it cannot wrap
  always_comb begin
    limit_s    = LIM_W'(half_r) << TO_SHIFT;
    wdog_exp_s = (LIM_W'(wdog_r) > limit_s) || (wdog_r == '1);
    id_legal_s = (CHK_W == 32'd0) ? 1'b1 : ((shreg_r >> (ID_W - CHK_W)) == '0);
  end

  // Frame FSM with counters and registered handshake outputs; flag sets are
  // written after the clear so a same-cycle set overrides it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      half_r    <= '0;
      timer_r   <= '0;
      wdog_r    <= '0;
      bit_cnt_r <= '0;
      shreg_r   <= '0;
      ID        <= '0;
      ID_vld    <= 1'b0;
      ID_err    <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (clr_ID_vld) begin
        ID_vld  <= 1'b0;
        ID_err  <= 1'b0;
        overrun <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!bc_s) begin
            state_r <= START;
            half_r  <= TMR_W'(1);
            busy    <= 1'b1;
          end
        end
        START: begin
          if (!bc_s) begin
            if (half_r == '1) state_r <= ABORT;
            else              half_r  <= half_r + TMR_W'(1);
          end else if (half_r < TMR_W'(MIN_HALF)) begin
            state_r <= IDLE;
            half_r  <= '0;
            busy    <= 1'b0;
          end else begin
            state_r <= WAIT_FALL;
            wdog_r  <= '0;
          end
        end
        WAIT_FALL: begin
          if (!bc_s) begin
            state_r <= DELAY;
            timer_r <= TMR_W'(1);
          end else if (wdog_exp_s) begin
            state_r <= ABORT;
          end else begin
            wdog_r <= wdog_r + TMR_W'(1);
          end
        end
        DELAY: begin
          if (timer_r < half_r) begin
            timer_r <= timer_r + TMR_W'(1);
          end else begin
            shreg_r <= {shreg_r[ID_W-2:0], bc_s};
            timer_r <= '0;
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= DONE;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              state_r   <= WAIT_RISE;
              wdog_r    <= '0;
            end
          end
        end
        WAIT_RISE: begin
          if (bc_s) begin
            state_r <= WAIT_FALL;
            wdog_r  <= '0;
          end else if (wdog_exp_s) begin
            state_r <= ABORT;
          end else begin
            wdog_r <= wdog_r + TMR_W'(1);
          end
        end
        DONE: begin
          if (id_legal_s) begin
            ID     <= shreg_r;
            ID_vld <= 1'b1;
            if (ID_vld) overrun <= 1'b1;
          end else begin
            ID_err <= 1'b1;
          end
          state_r <= WAIT_IDLE;
        end
        ABORT: begin
          ID_err  <= 1'b1;
          state_r <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          half_r    <= '0;
          bit_cnt_r <= '0;
          timer_r   <= '0;
          wdog_r    <= '0;
          if (bc_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_rx_param.sv
// Scoreboard bench: expected frame results are queued by the stimulus and
// checked by per-DUT monitors each time a DUT returns to idle.
module tb_barcode_rx_param;

  localparam int H = 50;

  typedef struct packed {
    logic [31:0] id;
    logic        vld;
    logic        err;
    logic        ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst0_n, rst1_n, bc0, bc1, clr0, clr1;
  logic [7:0]  id0;
  logic [11:0] id1;
  logic vld0, err0, ovr0, busy0;
  logic vld1, err1, ovr1, busy1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int last_rise_cyc = 0;
  int vld_rise_cyc = 0;
  int err_rise_cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic busy0_q = 1'b0, vld0_q = 1'b0, err0_q = 1'b0, busy1_q = 1'b0;

  barcode_rx_param u0 (
    .clk(clk), .rst_n(rst0_n), .BC(bc0), .clr_ID_vld(clr0),
    .ID(id0), .ID_vld(vld0), .ID_err(err0), .overrun(ovr0), .busy(busy0)
  );

  barcode_rx_param #(.ID_W(12), .CHK_W(0)) u1 (
    .clk(clk), .rst_n(rst1_n), .BC(bc1), .clr_ID_vld(clr1),
    .ID(id1), .ID_vld(vld1), .ID_err(err1), .overrun(ovr1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_range(input string name, input int val, input int lo, input int hi);
    total++;
    if (val < lo || val > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endfunction

  function automatic void exp_push(input bit sel, input logic [31:0] id, input logic vld, input logic err, input logic ovr);
    exp_t e;
    e.id = id; e.vld = vld; e.err = err; e.ovr = ovr;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endfunction

  // Monitor for the 8-bit receiver: a frame outcome is checked when busy drops
  always @(negedge clk) begin
    if (rst0_n && busy0_q && !busy0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_frame: got id=%h with no expected entry", id0);
      end else begin
        e0 = q0.pop_front();
        check("dut0_frame", {id0, vld0, err0, ovr0}, {e0.id[7:0], e0.vld, e0.err, e0.ovr});
      end
    end
    if (vld0 && !vld0_q) vld_rise_cyc = cyc;
    if (err0 && !err0_q) err_rise_cyc = cyc;
    busy0_q = busy0; vld0_q = vld0; err0_q = err0;
  end

  // Monitor for the 12-bit receiver
  always @(negedge clk) begin
    if (rst1_n && busy1_q && !busy1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_frame: got id=%h with no expected entry", id1);
      end else begin
        e1 = q1.pop_front();
        check("dut1_frame", {id1, vld1, err1, ovr1}, {e1.id[11:0], e1.vld, e1.err, e1.ovr});
      end
    end
    busy1_q = busy1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bc(input bit sel, input logic v);
    if (sel) bc1 = v;
    else     bc0 = v;
  endtask

  // Start bit of H, then per bit: 1 = short low, 0 = long low, 2H per bit.
  // A partial frame stops right after the last sent bit's rising edge.
  task automatic send(input bit sel, input logic [31:0] val, input int w, input int nsend);
    set_bc(sel, 1'b0); tick(H);
    set_bc(sel, 1'b1); tick(H / 2);
    for (int i = 0; i < nsend; i++) begin
      logic b;
      b = val[w - 1 - i];
      set_bc(sel, 1'b0);
      last_fall_cyc = cyc;
      tick(b ? H / 2 : 3 * H / 2);
      set_bc(sel, 1'b1);
      last_rise_cyc = cyc;
      if (nsend == w || i != nsend - 1) tick(b ? 3 * H / 2 : H / 2);
    end
  endtask

  task automatic wait_idle(input bit sel, input int budget);
    int n;
    n = 0;
    while ((sel ? busy1 : busy0) && n < budget) begin
      tick(1);
      n++;
    end
    if (sel ? busy1 : busy0) begin
      total++; bad++;
      $display("FAIL wait_idle: dut%0d still busy after %0d cycles", sel, budget);
    end
    tick(3);
  endtask

  task automatic pulse_clr0();
    clr0 = 1'b1; tick(1); clr0 = 1'b0;
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; bc0 = 1'b1; bc1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    tick(3);
    check("reset_dut0", {id0, vld0, err0, ovr0, busy0}, 64'h0);
    check("reset_dut1", {id1, vld1, err1, ovr1, busy1}, 64'h0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    tick(5);

    // Legal frame, then its latency from the last falling edge
    exp_push(1'b0, 32'h2A, 1'b1, 1'b0, 1'b0);
    send(1'b0, 32'h2A, 8, 8);
    wait_idle(1'b0, 1000);
    check_range("latency_2a", vld_rise_cyc - last_fall_cyc, 50, 60);

    // Illegal MSBs: error flag, ID keeps 0x2A
    pulse_clr0();
    check("clr_before_c5", {vld0, err0, ovr0}, 64'h0);
    exp_push(1'b0, 32'h2A, 1'b0, 1'b1, 1'b0);
    send(1'b0, 32'hC5, 8, 8);
    wait_idle(1'b0, 1000);

    // Short glitch: no flags change
    pulse_clr0();
    exp_push(1'b0, 32'h2A, 1'b0, 1'b0, 1'b0);
    bc0 = 1'b0; tick(10); bc0 = 1'b1;
    wait_idle(1'b0, 100);

    // Stall after three bits: watchdog abort about 8H cycles later
    exp_push(1'b0, 32'h2A, 1'b0, 1'b1, 1'b0);
    send(1'b0, 32'h40, 8, 3);
    wait_idle(1'b0, 1000);
    check_range("timeout_delay", err_rise_cyc - last_rise_cyc, 399, 409);

    // Two legal frames without clear: overrun, then clear everything
    pulse_clr0();
    exp_push(1'b0, 32'h11, 1'b1, 1'b0, 1'b0);
    send(1'b0, 32'h11, 8, 8);
    wait_idle(1'b0, 1000);
    exp_push(1'b0, 32'h22, 1'b1, 1'b0, 1'b1);
    send(1'b0, 32'h22, 8, 8);
    wait_idle(1'b0, 1000);
    pulse_clr0();
    check("clr_after_overrun", {id0, vld0, err0, ovr0}, {8'h22, 3'b000});

    // 12-bit receiver with no checked MSBs
    exp_push(1'b1, 32'hFA5, 1'b1, 1'b0, 1'b0);
    send(1'b1, 32'hFA5, 12, 12);
    wait_idle(1'b1, 1000);

    // Reset mid-frame, then a complete frame decodes normally
    send(1'b1, 32'h5A3, 12, 6);
    rst1_n = 1'b0;
    tick(1);
    check("reset_mid_frame", {id1, vld1, err1, ovr1, busy1}, 64'h0);
    rst1_n = 1'b1;
    tick(5);
    exp_push(1'b1, 32'h3C7, 1'b1, 1'b0, 1'b0);
    send(1'b1, 32'h3C7, 12, 12);
    wait_idle(1'b1, 1000);

    for (int i = 0; i < 100 && (q0.size() + q1.size()) != 0; i++) tick(1);
    if ((q0.size() + q1.size()) != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q0.size() + q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
